// File: rtl/ctrl_exec_pkg.sv
// Shared types and constants for the ctrl_executor block: FSM states,
// register-file geometry and the captured control word.
package ctrl_exec_pkg;

  localparam int REG_IDX_W = 2;
  localparam int REG_COUNT = 4;
  // Wide enough for MEM_LAT-1 with MEM_LAT up to 15.
  localparam int LAT_W     = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MEM  = 2'd1,
    WB   = 2'd2
  } state_t;

  typedef struct packed {
    logic                 reg_write_enable;
    logic                 mem_read;
    logic                 mem_write;
    logic                 alu_op;
    logic [REG_IDX_W-1:0] rd;
    logic [REG_IDX_W-1:0] rs1;
    logic [REG_IDX_W-1:0] rs2;
  } ctrl_word_t;

  // Asking for a read and a write at once has no defined meaning.
  function automatic logic is_illegal(ctrl_word_t w);
    return w.mem_read && w.mem_write;
  endfunction

  // Only legal words that touch data memory pay the memory latency.
  function automatic logic needs_mem(ctrl_word_t w);
    return (w.mem_read || w.mem_write) && !is_illegal(w);
  endfunction

endpackage

// File: rtl/ctrl_exec_if.sv
// Control-word handshake and completion bundle between the opcode decoder
// (master) and ctrl_executor (slave).
interface ctrl_exec_if #(
  parameter int DATA_W    = 8,
  parameter int MEM_DEPTH = 16
);
  import ctrl_exec_pkg::*;

  localparam int ADDR_W = $clog2(MEM_DEPTH);

  logic                 ctrl_valid;
  logic                 ctrl_ready;
  logic                 reg_write_enable;
  logic                 mem_read;
  logic                 mem_write;
  logic                 alu_op;
  logic [REG_IDX_W-1:0] rd;
  logic [REG_IDX_W-1:0] rs1;
  logic [REG_IDX_W-1:0] rs2;
  logic [ADDR_W-1:0]    mem_addr;
  logic                 done;
  logic                 err;
  logic [DATA_W-1:0]    result;
  logic                 busy;

  modport master (
    output ctrl_valid, reg_write_enable, mem_read, mem_write, alu_op,
           rd, rs1, rs2, mem_addr,
    input  ctrl_ready, done, err, result, busy
  );

  modport slave (
    input  ctrl_valid, reg_write_enable, mem_read, mem_write, alu_op,
           rd, rs1, rs2, mem_addr,
    output ctrl_ready, done, err, result, busy
  );

endinterface

// File: rtl/ctrl_exec_regfile.sv
// 4 x DATA_W register file: two combinational read ports, one write port.
// Optional feature macro: CTRL_EXEC_R0_ZERO_EN hardwires R0 to zero by
// discarding writes to index 0; otherwise R0 is an ordinary register.
module ctrl_exec_regfile
  import ctrl_exec_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 we,
  input  logic [REG_IDX_W-1:0] waddr,
  input  logic [DATA_W-1:0]    wdata,
  input  logic [REG_IDX_W-1:0] raddr1,
  input  logic [REG_IDX_W-1:0] raddr2,
  output logic [DATA_W-1:0]    rdata1,
  output logic [DATA_W-1:0]    rdata2
);

  logic [DATA_W-1:0] regs [REG_COUNT];
  logic              wr_allow;

`ifdef CTRL_EXEC_R0_ZERO_EN
  // R0 stays at its reset value of zero because it is never written.
  assign wr_allow = (waddr != '0);
`else
  assign wr_allow = 1'b1;
`endif

  // Register storage; cleared on reset, written on a single port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the array lives in flops with a reset loop, not RAM, because
      // reset must clear every entry; <= keeps all updates edge-parallel.
      for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
    end else if (we && wr_allow) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata1 = regs[raddr1];
  assign rdata2 = regs[raddr2];

endmodule

// File: rtl/ctrl_executor.sv
// Multi-cycle executor behind the opcode decoder: accepts a control word,
// optionally waits MEM_LAT cycles for data memory, then commits LOAD,
// STORE, ADD/SUB or NOP and pulses done (and err for illegal words).
// Optional feature macro: CTRL_EXEC_R0_ZERO_EN (handled in the register file).
// MEM_LAT must lie in 1..15.
module ctrl_executor
  import ctrl_exec_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int MEM_DEPTH = 16,
  parameter int MEM_LAT   = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  ctrl_exec_if.slave bus
);

  localparam int               ADDR_W   = $clog2(MEM_DEPTH);
  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(MEM_LAT - 1);

  state_t            state;
  ctrl_word_t        word_q;
  logic [ADDR_W-1:0] addr_q;
  logic [LAT_W-1:0]  lat_cnt;
  logic              done_q;
  logic              err_q;
  logic [DATA_W-1:0] result_q;
  logic [DATA_W-1:0] dmem [MEM_DEPTH];

  ctrl_word_t        in_word;
  logic [DATA_W-1:0] rs1_data;
  logic [DATA_W-1:0] rs2_data;
  logic [DATA_W-1:0] wb_value;
  logic              rf_we;
  logic              mem_we;

  assign in_word = '{
    reg_write_enable: bus.reg_write_enable,
    mem_read:         bus.mem_read,
    mem_write:        bus.mem_write,
    alu_op:           bus.alu_op,
    rd:               bus.rd,
    rs1:              bus.rs1,
    rs2:              bus.rs2
  };

  // Operands are read during WB so a preceding commit is always visible.
  ctrl_exec_regfile #(
    .DATA_W (DATA_W)
  ) u_regfile (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (rf_we),
    .waddr  (word_q.rd),
    .wdata  (wb_value),
    .raddr1 (word_q.rs1),
    .raddr2 (word_q.rs2),
    .rdata1 (rs1_data),
    .rdata2 (rs2_data)
  );

  // Value committed in WB; an illegal word leaves the old result in place.
  always_comb begin
    // NOTE: defaulting first means every path assigns wb_value, so no latch.
    wb_value = '0;
    if (is_illegal(word_q)) begin
      wb_value = result_q;
    end else if (word_q.mem_read) begin
      wb_value = dmem[addr_q];
    end else if (word_q.mem_write) begin
      wb_value = rs2_data;
    end else if (word_q.reg_write_enable) begin
      wb_value = word_q.alu_op ? (rs1_data - rs2_data) : (rs1_data + rs2_data);
    end
  end

  // Stores never write a register; mem_write also covers the illegal case.
  assign rf_we  = (state == WB) && word_q.reg_write_enable && !word_q.mem_write;
  assign mem_we = (state == WB) && word_q.mem_write && !word_q.mem_read;

  // Control FSM: capture on accept, count memory latency, commit in WB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      word_q   <= '0;
      addr_q   <= '0;
      lat_cnt  <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      result_q <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.ctrl_valid) begin
            word_q <= in_word;
            addr_q <= bus.mem_addr;
            if (needs_mem(in_word)) begin
              state   <= MEM;
              lat_cnt <= LAT_LOAD;
            end else begin
              state  <= WB;
              done_q <= 1'b1;
              err_q  <= is_illegal(in_word);
            end
          end
        end
        MEM: begin
          if (lat_cnt == '0) begin
            state  <= WB;
            done_q <= 1'b1;
          end else begin
            lat_cnt <= lat_cnt - 1'b1;
          end
        end
        WB: begin
          result_q <= wb_value;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Data memory; cleared on reset so an interrupted store leaves no trace.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MEM_DEPTH; i++) dmem[i] <= '0;
    end else if (mem_we) begin
      dmem[addr_q] <= rs2_data;
    end
  end

  assign bus.ctrl_ready = (state == IDLE);
  assign bus.busy       = (state != IDLE);
  assign bus.done       = done_q;
  assign bus.err        = err_q;
  // During WB the committing value is shown alongside done.
  assign bus.result     = (state == WB) ? wb_value : result_q;

endmodule
